alu_issue_stage: RTL and testbench

// Operand-fetch/issue and writeback stage wrapped around the combinational ALU.
// - Holds an NREG x W register file.
// - Accepts one decoded instruction per cycle over a valid/ready handshake.
// - Drives registered A/B/OP into the ALU, then writes the ALU result and flags back the next cycle.
// - Forwards the in-flight result to a dependent instruction that immediately follows it.

---
 rtl/alu_issue_stage.sv | 110 +++++++++++
 tb/tb_alu_issue_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Operand-fetch/issue and writeback stage around an external combinational ALU.
// One instruction per cycle; the in-flight ALU result is forwarded to the next instruction.
module alu_issue_stage #(
  parameter int W    = 8,
  parameter int Ops  = 3,
  parameter int NREG = 8,
  parameter int RA   = 3
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [Ops-1:0] in_op,
  input  logic [RA-1:0]  in_rd,
  input  logic [RA-1:0]  in_rs,
  input  logic [RA-1:0]  in_rt,
  input  logic           in_imm_en,
  input  logic [W-1:0]   in_imm,
  input  logic           Hold,
  output logic [W-1:0]   A,
  output logic [W-1:0]   B,
  output logic [Ops-1:0] OP,
  input  logic [W-1:0]   alu_out,
  input  logic           alu_zero,
  input  logic           alu_sign,
  output logic           ex_valid,
  output logic           Z_flag,
  output logic           S_flag,
  input  logic [RA-1:0]  dbg_addr,
  output logic [W-1:0]   dbg_data
);

  // Handshake: an instruction transfers on an edge where in_valid && in_ready;
  // in_ready is simply !Hold, and upstream keeps in_* stable while Hold is high.

  logic [W-1:0]   regs_q [NREG];
  logic [W-1:0]   regs_d [NREG];
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [Ops-1:0] op_q, op_d;
  logic [RA-1:0]  ex_rd_q, ex_rd_d;
  logic           ex_valid_q, ex_valid_d;
  logic           z_q, z_d;
  logic           s_q, s_d;
  logic [W-1:0]   fwd_rs, fwd_rt;

  // The instruction in the ALU writes back on the same edge the next one samples
  // its operands, so a matching source must take alu_out instead of the stale register.
  assign fwd_rs = (ex_valid_q && (in_rs == ex_rd_q)) ? alu_out : regs_q[in_rs];
  assign fwd_rt = (ex_valid_q && (in_rt == ex_rd_q)) ? alu_out : regs_q[in_rt];

  always_comb begin
    regs_d     = regs_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    ex_rd_d    = ex_rd_q;
    ex_valid_d = ex_valid_q;
    z_d        = z_q;
    s_d        = s_q;
    if (!Hold) begin
      if (ex_valid_q) begin
        regs_d[ex_rd_q] = alu_out;
        z_d             = alu_zero;
        s_d             = alu_sign;
      end
      ex_valid_d = in_valid;
      if (in_valid) begin
        a_d     = fwd_rs;
        b_d     = in_imm_en ? in_imm : fwd_rt;
        op_d    = in_op;
        ex_rd_d = in_rd;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      ex_rd_q    <= '0;
      ex_valid_q <= 1'b0;
      z_q        <= 1'b0;
      s_q        <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      ex_rd_q    <= ex_rd_d;
      ex_valid_q <= ex_valid_d;
      z_q        <= z_d;
      s_q        <= s_d;
    end
  end

  assign in_ready = !Hold;
  assign A        = a_q;
  assign B        = b_q;
  assign OP       = op_q;
  assign ex_valid = ex_valid_q;
  assign Z_flag   = z_q;
  assign S_flag   = s_q;
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: an architectural register-file model predicts operands
// and flags; a negedge monitor pops the expected queue whenever the DUT issues to the ALU.
module tb_alu_issue_stage;
  localparam int W    = 8;
  localparam int OPS  = 3;
  localparam int NREG = 8;
  localparam int RA   = 3;

  logic           clk;
  logic           Reset_n;
  logic           in_valid;
  logic           in_ready;
  logic [OPS-1:0] in_op;
  logic [RA-1:0]  in_rd, in_rs, in_rt;
  logic           in_imm_en;
  logic [W-1:0]   in_imm;
  logic           Hold;
  logic [W-1:0]   A, B;
  logic [OPS-1:0] OP;
  logic [W-1:0]   alu_out;
  logic           alu_zero, alu_sign;
  logic           ex_valid, Z_flag, S_flag;
  logic [RA-1:0]  dbg_addr;
  logic [W-1:0]   dbg_data;

  alu_issue_stage #(.W(W), .Ops(OPS), .NREG(NREG), .RA(RA)) dut (
    .Clk(clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .in_imm_en(in_imm_en), .in_imm(in_imm), .Hold(Hold),
    .A(A), .B(B), .OP(OP), .alu_out(alu_out), .alu_zero(alu_zero), .alu_sign(alu_sign),
    .ex_valid(ex_valid), .Z_flag(Z_flag), .S_flag(S_flag),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ALU model (stands in for the real ALU) ----------------
  function automatic logic [W-1:0] alu_f(input logic [OPS-1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      3'd0:    alu_f = a + b;
      3'd1:    alu_f = a - b;
      3'd2:    alu_f = a & b;
      3'd3:    alu_f = a ^ b;
      3'd4:    alu_f = a | b;
      3'd5:    alu_f = ~a;
      3'd6:    alu_f = a << 1;
      default: alu_f = b;
    endcase
  endfunction

  assign alu_out  = alu_f(OP, A, B);
  assign alu_zero = (alu_out == '0);
  assign alu_sign = alu_out[W-1];

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [OPS-1:0] op;
    logic           z;
    logic           s;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] ref_regs [NREG];
  int           total = 0;
  int           bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  exp_t mon_e;
  logic pend = 1'b0;
  logic pend_z, pend_s;

  always @(negedge clk) begin
    if (pend) begin
      chk("wb_Z_flag", Z_flag, pend_z);
      chk("wb_S_flag", S_flag, pend_s);
      pend = 1'b0;
    end
    if (Reset_n === 1'b1 && ex_valid === 1'b1 && Hold === 1'b0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL exp_q_underflow: got=issue want=none (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("issue_A", A, mon_e.a);
        chk("issue_B", B, mon_e.b);
        chk("issue_OP", OP, mon_e.op);
        pend   = 1'b1;
        pend_z = mon_e.z;
        pend_s = mon_e.s;
      end
    end else if (Reset_n === 1'b0 && ex_valid === 1'b1 && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();  // dropped by reset, never written back
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [OPS-1:0] op, input logic [RA-1:0] rd, input logic [RA-1:0] rs,
                       input logic [RA-1:0] rt, input logic imm_en, input logic [W-1:0] imm,
                       input int hold_cycles);
    exp_t         e;
    logic [W-1:0] a, b, r;
    in_valid  = 1'b1;
    in_op     = op;
    in_rd     = rd;
    in_rs     = rs;
    in_rt     = rt;
    in_imm_en = imm_en;
    in_imm    = imm;
    Hold      = (hold_cycles > 0);
    for (int h = 0; h < hold_cycles; h++) begin
      @(posedge clk);
      #1;
      chk("hold_in_ready", in_ready, 0);
      if (exp_q.size() > 0) begin
        chk("hold_ex_valid", ex_valid, 1);
        chk("hold_A", A, exp_q[0].a);
        chk("hold_B", B, exp_q[0].b);
        chk("hold_OP", OP, exp_q[0].op);
      end
      if (h == hold_cycles - 1) Hold = 1'b0;
    end
    a = ref_regs[rs];
    b = imm_en ? imm : ref_regs[rt];
    r = alu_f(op, a, b);
    e.a  = a;
    e.b  = b;
    e.op = op;
    e.z  = (r == '0);
    e.s  = r[W-1];
    exp_q.push_back(e);
    ref_regs[rd] = r;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string name);
    for (int i = 0; i < NREG; i++) begin
      dbg_addr = RA'(i);
      #1;
      chk(name, dbg_data, ref_regs[i]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ref();
    for (int i = 0; i < NREG; i++) ref_regs[i] = '0;
  endtask

  // ---------------- stimulus ----------------
  logic [RA-1:0] prev_rd, rd_r;

  initial begin
    Reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_op     = 3'd0;
    in_rd     = 3'd1;
    in_rs     = 3'd2;
    in_rt     = 3'd3;
    in_imm_en = 1'b1;
    in_imm    = 8'h55;
    Hold      = 1'b0;
    dbg_addr  = '0;
    clear_ref();

    // Reset with in_valid held high
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_OP", OP, 0);
    chk("rst_Z", Z_flag, 0);
    chk("rst_S", S_flag, 0);
    for (int i = 0; i < NREG; i++) begin
      dbg_addr = RA'(i);
      #1;
      chk("rst_dbg", dbg_data, 0);
    end
    in_valid = 1'b0;
    Reset_n  = 1'b1;
    @(posedge clk);
    #1;

    // Immediate add: r1=5, r2 = r1 + 3
    issue(3'd7, 3'd1, 3'd0, 3'd0, 1'b1, 8'd5, 0);
    issue(3'd0, 3'd2, 3'd1, 3'd0, 1'b1, 8'd3, 0);
    chk("imm_A", A, 5);
    chk("imm_B", B, 3);
    dbg_addr = 3'd2;
    idle();
    chk("imm_r2", dbg_data, 8);
    chk("imm_Z", Z_flag, 0);
    chk("imm_S", S_flag, 0);

    // Back-to-back forwarding, rs==rt==in-flight rd
    issue(3'd7, 3'd3, 3'd0, 3'd0, 1'b1, 8'd3, 0);
    issue(3'd0, 3'd2, 3'd1, 3'd3, 1'b0, 8'd0, 0);
    issue(3'd3, 3'd4, 3'd2, 3'd2, 1'b0, 8'd0, 0);
    chk("fwd_A", A, 8);
    chk("fwd_B", B, 8);
    dbg_addr = 3'd4;
    idle();
    chk("fwd_r4", dbg_data, 0);
    chk("fwd_Z", Z_flag, 1);
    idle();
    check_regs("fwd_regs");

    // Hold mid-flight: r6 = 0x0c + 4 is frozen for 3 cycles
    issue(3'd7, 3'd5, 3'd0, 3'd0, 1'b1, 8'h0c, 0);
    issue(3'd0, 3'd6, 3'd5, 3'd0, 1'b1, 8'h04, 0);
    dbg_addr = 3'd6;
    Hold     = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("hm_in_ready", in_ready, 0);
      chk("hm_ex_valid", ex_valid, 1);
      chk("hm_A", A, 8'h0c);
      chk("hm_B", B, 8'h04);
      chk("hm_OP", OP, 0);
      chk("hm_r6", dbg_data, 0);
    end
    Hold = 1'b0;
    idle();
    chk("hm_r6_after", dbg_data, 8'h10);

    // Reset right after accept: destination must stay 0
    issue(3'd0, 3'd7, 3'd1, 3'd0, 1'b1, 8'd1, 0);
    Reset_n = 1'b0;
    @(posedge clk);
    #1;
    Reset_n = 1'b1;
    clear_ref();
    dbg_addr = 3'd7;
    #1;
    chk("rmid_ex_valid", ex_valid, 0);
    chk("rmid_r7", dbg_data, 0);
    chk("rmid_Z", Z_flag, 0);
    @(posedge clk);
    #1;

    // Sustained XOR stream with dependency chain, then a single-cycle gap
    for (int r = 0; r < NREG; r++) issue(3'd7, RA'(r), 3'd0, 3'd0, 1'b1, W'($urandom), 0);
    prev_rd = 3'd0;
    for (int k = 0; k < 8; k++) begin
      rd_r = RA'($urandom_range(0, NREG - 1));
      issue(3'd3, rd_r, prev_rd, RA'($urandom_range(0, NREG - 1)),
            1'($urandom_range(0, 1)), W'($urandom), 0);
      chk("stream_ex_valid", ex_valid, 1);
      prev_rd = rd_r;
    end
    idle();
    chk("gap_ex_valid", ex_valid, 0);
    issue(3'd3, 3'd1, prev_rd, 3'd2, 1'b0, 8'd0, 0);
    chk("gap_resume_ex_valid", ex_valid, 1);
    idle();
    idle();
    check_regs("stream_regs");

    // Random traffic with holds and gaps
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 5) == 0) idle();
      issue(OPS'($urandom_range(0, 7)), RA'($urandom_range(0, NREG - 1)),
            RA'($urandom_range(0, NREG - 1)), RA'($urandom_range(0, NREG - 1)),
            1'($urandom_range(0, 1)), W'($urandom),
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    idle();
    idle();
    check_regs("rand_regs");

    repeat (2) idle();
    chk("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
